mem_arbiter: RTL



---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, RAM and status signals of the single-port memory arbiter.
// master: datapath/cache side plus RAM model; slave: the arbiter itself.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ram_REN;
  logic        ram_WEN;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic        ram_ready;
  logic [31:0] ram_load;
  logic        busy;
  logic        err;
  logic [7:0]  err_count;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    input  ihit, iload, dhit, dload, ram_REN, ram_WEN, ram_addr, ram_store,
           busy, err, err_count
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ram_load,
    output ihit, iload, dhit, dload, ram_REN, ram_WEN, ram_addr, ram_store,
           busy, err, err_count
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data memory.
// Data is preferred, but at most DSTREAK_MAX data grants are made in a row
// while a fetch waits. A watchdog aborts RAM accesses that never complete;
// the aborted request stays held by its requester and is simply retried.
module mem_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ABORT} state_t;

  localparam logic [3:0] DMAX = 4'(DSTREAK_MAX);
  localparam logic [7:0] TMO  = 8'(TIMEOUT);

  state_t      state, next_state;
  logic        owner_d;
  logic        op_write;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic [31:0] load_q;
  logic [3:0]  streak;
  logic [7:0]  wdog;
  logic [7:0]  err_cnt;
  logic        d_req;
  logic        grant_d;
  logic        grant_i;
  logic        timeout_hit;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Grant selection and next-state decode
  always_comb begin
    next_state  = state;
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    d_req       = bus.dREN | bus.dWEN;
    timeout_hit = (TMO != 8'd0) && (wdog == TMO);
    case (state)
      IDLE: begin
        if (d_req && ((streak < DMAX) || !bus.iREN)) begin
          grant_d    = 1'b1;
          next_state = ACCESS;
        end else if (bus.iREN) begin
          grant_i    = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        // ram_ready wins over a watchdog expiry in the same cycle
        if (bus.ram_ready)    next_state = RESP;
        else if (timeout_hit) next_state = ABORT;
      end
      RESP:    next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transaction latches, streak, watchdog and abort counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_d  <= 1'b0;
      op_write <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      load_q   <= '0;
      streak   <= '0;
      wdog     <= '0;
      err_cnt  <= '0;
    end else begin
      if (grant_d || grant_i) begin
        owner_d  <= grant_d;
        op_write <= grant_d & bus.dWEN;
        addr_q   <= grant_d ? bus.daddr : bus.iaddr;
        store_q  <= (grant_d && bus.dWEN) ? bus.dstore : '0;
        load_q   <= '0;
        wdog     <= '0;
      end
      if (grant_i)
        streak <= '0;
      else if (grant_d)
        streak <= bus.iREN ? streak + 4'd1 : '0;
      if (state == ACCESS) begin
        if (bus.ram_ready) begin
          if (!op_write) load_q <= bus.ram_load;
        end else begin
          wdog <= wdog + 8'd1;
        end
      end
      if (state == ABORT && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  // Outputs decode registered state only
  always_comb begin
    bus.ram_REN   = (state == ACCESS) && !op_write;
    bus.ram_WEN   = (state == ACCESS) && op_write;
    bus.ram_addr  = (state == ACCESS) ? addr_q : '0;
    bus.ram_store = ((state == ACCESS) && op_write) ? store_q : '0;
    bus.ihit      = (state == RESP) && !owner_d;
    bus.dhit      = (state == RESP) && owner_d;
    bus.iload     = ((state == RESP) && !owner_d) ? load_q : '0;
    bus.dload     = ((state == RESP) && owner_d && !op_write) ? load_q : '0;
    bus.err       = (state == ABORT);
    bus.busy      = (state != IDLE);
    bus.err_count = err_cnt;
  end

endmodule
